// File: rtl/sram_rd_pkg.sv
// Shared types and default widths for the SRAM read sequencer.
// Optional feature macro used by the sequencer: SRAM_RD_BACK2BACK_EN.
package sram_rd_pkg;

    localparam int DEF_BIT_ADDR_EX = 19;
    localparam int DEF_BIT_CHIP    = 6;
    localparam int DEF_DATA_W      = 16;

    // Width of the wait-state down-counter; covers WAIT_CYC up to 15.
    localparam int WAIT_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_read_sequencer_if.sv
// Request / result channel between the address-extension stage and the
// sequencer. master = requester, slave = sequencer.
interface sram_read_sequencer_if
    import sram_rd_pkg::*;
#(
    parameter int BIT_ADDR_EX = DEF_BIT_ADDR_EX,
    parameter int BIT_CHIP    = DEF_BIT_CHIP,
    parameter int DATA_W      = DEF_DATA_W
);

    logic                            req_valid;
    logic                            req_ready;
    logic [BIT_ADDR_EX+BIT_CHIP-1:0] req_addr;
    logic                            rd_valid;
    logic [DATA_W-1:0]               rd_data;
    logic                            rd_err;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rd_valid, rd_data, rd_err
    );

endinterface

// File: rtl/sram_read_sequencer_chip_decode.sv
// Chip index -> one-hot active-low chip enable plus in-range flag.
// Out-of-range indices yield all enables high.
module sram_chip_decode
    import sram_rd_pkg::*;
#(
    parameter int BIT_CHIP = DEF_BIT_CHIP,
    parameter int NUM_CHIP = 4
) (
    input  logic [BIT_CHIP-1:0] chip,
    output logic [NUM_CHIP-1:0] ce_n,
    output logic                in_range
);

    // Decode the chip field; one extra bit so NUM_CHIP == 2**BIT_CHIP fits.
    always_comb begin
        in_range = ({1'b0, chip} < (BIT_CHIP+1)'(NUM_CHIP));
        ce_n     = '1;
        for (int i = 0; i < NUM_CHIP; i++) begin
            if (chip == BIT_CHIP'(i)) begin
                ce_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sram_read_sequencer.sv
// Wait-stated asynchronous SRAM read sequencer: one outstanding read,
// valid/ready request, one-cycle result pulse.
// Optional: SRAM_RD_BACK2BACK_EN lets a new request be accepted in CAPTURE
// so consecutive reads skip the IDLE cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access; ce_n/oe_n high; ready for a request
// SETUP   | address and ce_n/oe_n driven, first cycle of the access
// WAIT    | WAIT_CYC wait states, down-counter runs to terminal count
// CAPTURE | data sampled at the closing edge, result strobed
module sram_read_sequencer
    import sram_rd_pkg::*;
#(
    parameter int BIT_ADDR_EX = DEF_BIT_ADDR_EX,
    parameter int BIT_CHIP    = DEF_BIT_CHIP,
    parameter int NUM_CHIP    = 4,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYC    = 2
) (
    input  logic                    clk,
    input  logic                    clr_n,
    sram_read_sequencer_if.slave    bus,
    output logic [BIT_ADDR_EX-1:0]  sram_addr,
    output logic [NUM_CHIP-1:0]     sram_ce_n,
    output logic                    sram_oe_n,
    input  logic [DATA_W-1:0]       sram_dq_in
);

    // WAIT is entered with WAIT_CYC-1 so it lasts exactly WAIT_CYC cycles.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYC > 0) ? WAIT_CNT_W'(WAIT_CYC - 1) : '0;

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    err_pend;
    logic [BIT_CHIP-1:0]     req_chip;
    logic [BIT_ADDR_EX-1:0]  req_word;
    logic [NUM_CHIP-1:0]     dec_ce_n;
    logic                    dec_in_range;
    logic                    handshake;

    assign req_chip = bus.req_addr[BIT_ADDR_EX +: BIT_CHIP];
    assign req_word = bus.req_addr[BIT_ADDR_EX-1:0];

    sram_chip_decode #(
        .BIT_CHIP (BIT_CHIP),
        .NUM_CHIP (NUM_CHIP)
    ) u_decode (
        .chip     (req_chip),
        .ce_n     (dec_ce_n),
        .in_range (dec_in_range)
    );

    // Ready depends only on state so the requester never sees a loop.
    always_comb begin
`ifdef SRAM_RD_BACK2BACK_EN
        bus.req_ready = (state == IDLE) || (state == CAPTURE);
`else
        bus.req_ready = (state == IDLE);
`endif
    end

    assign handshake = bus.req_valid & bus.req_ready;

    // Sequencer FSM with registered SRAM strobes and result outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            err_pend     <= 1'b0;
            sram_addr    <= '0;
            sram_ce_n    <= '1;
            sram_oe_n    <= 1'b1;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_err   <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;

            // An out-of-range request reports one edge after its handshake.
            if (err_pend) begin
                bus.rd_valid <= 1'b1;
                bus.rd_err   <= 1'b1;
                bus.rd_data  <= '0;
                err_pend     <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (handshake) begin
                        if (dec_in_range) begin
                            state     <= SETUP;
                            sram_addr <= req_word;
                            sram_ce_n <= dec_ce_n;
                            sram_oe_n <= 1'b0;
                        end else begin
                            err_pend  <= 1'b1;
                        end
                    end
                end

                SETUP: begin
                    if (WAIT_CYC > 0) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state    <= CAPTURE;
                    end
                end

                WAIT: begin
                    if (wait_cnt == '0) begin
                        state    <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                CAPTURE: begin
                    bus.rd_data  <= sram_dq_in;
                    bus.rd_valid <= 1'b1;
                    bus.rd_err   <= 1'b0;
                    sram_ce_n    <= '1;
                    sram_oe_n    <= 1'b1;
                    state        <= IDLE;
`ifdef SRAM_RD_BACK2BACK_EN
                    // Chain straight into the next access; oe_n never rises.
                    if (handshake) begin
                        if (dec_in_range) begin
                            state     <= SETUP;
                            sram_addr <= req_word;
                            sram_ce_n <= dec_ce_n;
                            sram_oe_n <= 1'b0;
                        end else begin
                            err_pend  <= 1'b1;
                        end
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_read_sequencer.sv
// Self-checking bench for sram_read_sequencer. Two instances (WAIT_CYC=2 and
// WAIT_CYC=0) share the stimulus; 'sel' routes requests to one of them and
// selects whose outputs are observed. Expected behaviour is derived from the
// access timeline: ce_n/oe_n low for WAIT+2 cycles after the handshake edge,
// result on the WAIT+2'th edge, error result one edge after its handshake.
module tb_sram_read_sequencer;

    localparam int AW = 19;
    localparam int CW = 6;
    localparam int NC = 4;
    localparam int DW = 16;

`ifdef SRAM_RD_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr_n;
    logic          req_valid;
    logic [AW+CW-1:0] req_addr;
    logic [DW-1:0] dq;
    int            sel;
    int            wc;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    sram_read_sequencer_if #(.BIT_ADDR_EX(AW), .BIT_CHIP(CW), .DATA_W(DW)) bus2 ();
    sram_read_sequencer_if #(.BIT_ADDR_EX(AW), .BIT_CHIP(CW), .DATA_W(DW)) bus0 ();

    logic [AW-1:0] sa2, sa0;
    logic [NC-1:0] ce2, ce0;
    logic          oe2, oe0;

    assign bus2.req_valid = req_valid && (sel == 0);
    assign bus0.req_valid = req_valid && (sel == 1);
    assign bus2.req_addr  = req_addr;
    assign bus0.req_addr  = req_addr;

    sram_read_sequencer #(
        .BIT_ADDR_EX(AW), .BIT_CHIP(CW), .NUM_CHIP(NC), .DATA_W(DW), .WAIT_CYC(2)
    ) dut2 (
        .clk(clk), .clr_n(clr_n), .bus(bus2), .sram_addr(sa2),
        .sram_ce_n(ce2), .sram_oe_n(oe2), .sram_dq_in(dq)
    );

    sram_read_sequencer #(
        .BIT_ADDR_EX(AW), .BIT_CHIP(CW), .NUM_CHIP(NC), .DATA_W(DW), .WAIT_CYC(0)
    ) dut0 (
        .clk(clk), .clr_n(clr_n), .bus(bus0), .sram_addr(sa0),
        .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_dq_in(dq)
    );

    logic          o_ready, o_rv, o_err, o_oe;
    logic [DW-1:0] o_data;
    logic [AW-1:0] o_addr;
    logic [NC-1:0] o_ce;

    assign o_ready = (sel == 1) ? bus0.req_ready : bus2.req_ready;
    assign o_rv    = (sel == 1) ? bus0.rd_valid  : bus2.rd_valid;
    assign o_err   = (sel == 1) ? bus0.rd_err    : bus2.rd_err;
    assign o_data  = (sel == 1) ? bus0.rd_data   : bus2.rd_data;
    assign o_addr  = (sel == 1) ? sa0 : sa2;
    assign o_ce    = (sel == 1) ? ce0 : ce2;
    assign o_oe    = (sel == 1) ? oe0 : oe2;

    function automatic logic [NC-1:0] ce_exp(input int c);
        logic [NC-1:0] v;
        v    = '1;
        v[c] = 1'b0;
        return v;
    endfunction

    // Called at a sample point (just after a falling edge) with ready expected.
    task automatic start(input logic [AW+CW-1:0] a, input logic [DW-1:0] d);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: got %b expected 1", o_ready);
        end
        req_valid = 1'b1;
        req_addr  = a;
        dq        = d;
    endtask

    // Follows one in-range access cycle by cycle after its handshake edge.
    // next_valid requests a follow-on access at the first ready cycle.
    task automatic watch(input int chip, input logic [AW-1:0] word,
                         input logic [DW-1:0] data, input int start_i,
                         input bit junk, input bit next_valid,
                         input logic [AW+CW-1:0] next_addr);
        bit            chain;
        bit            busy, last, exp_ready, exp_oe;
        int            ready_at;
        logic [NC-1:0] exp_ce;
        logic [AW-1:0] exp_addr;
        chain    = next_valid && B2B;
        ready_at = B2B ? wc + 1 : wc + 2;
        for (int i = start_i; i <= wc + 2; i++) begin
            @(negedge clk);
            busy      = (i <= wc + 1);
            last      = (i == wc + 2);
            exp_ce    = busy ? ce_exp(chip)
                      : ((chain && last) ? ce_exp(int'(next_addr[AW+CW-1:AW])) : '1);
            exp_oe    = (busy || (chain && last)) ? 1'b0 : 1'b1;
            exp_ready = (i >= ready_at) && !(chain && last);
            exp_addr  = (chain && last) ? next_addr[AW-1:0] : word;
            checks++;
            if ({o_ce, o_oe, o_rv, o_ready, o_addr} !==
                {exp_ce, exp_oe, last, exp_ready, exp_addr}) begin
                errors++;
                $display("FAIL access_step %0d: got ce=%b oe=%b rv=%b rdy=%b addr=%h expected ce=%b oe=%b rv=%b rdy=%b addr=%h",
                         i, o_ce, o_oe, o_rv, o_ready, o_addr,
                         exp_ce, exp_oe, last, exp_ready, exp_addr);
            end
            if (last) begin
                checks++;
                if ({o_data, o_err} !== {data, 1'b0}) begin
                    errors++;
                    $display("FAIL read_data: got data=%h err=%b expected data=%h err=0",
                             o_data, o_err, data);
                end
            end
            if (i < ready_at) begin
                if (junk) begin
                    req_valid = 1'b1;
                    req_addr  = (AW+CW)'($urandom);
                end else begin
                    req_valid = 1'b0;
                end
            end else if (i == ready_at) begin
                req_valid = next_valid;
                if (next_valid) req_addr = next_addr;
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic random_reads(input int n);
        int            c;
        logic [AW-1:0] w;
        logic [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            c = int'($urandom_range(0, NC - 1));
            w = AW'($urandom);
            d = DW'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start({CW'(c), w}, d);
            watch(c, w, d, 0, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic test_reset();
        bit saw_rv;
        sel = 0; wc = 2;
        clr_n = 1'b0; req_valid = 1'b0; req_addr = '0; dq = '0;
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_ready, o_ce, o_oe, o_rv, o_err, o_data, o_addr} !==
            {1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0, 19'h0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b ce=%b oe=%b rv=%b err=%b data=%h addr=%h expected 1 1111 1 0 0 0000 00000",
                     o_ready, o_ce, o_oe, o_rv, o_err, o_data, o_addr);
        end
        req_valid = 1'b1;
        req_addr  = {6'd1, 19'h02345};
        dq        = 16'h5A5A;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_ce, o_oe} !== {4'b1101, 1'b0}) begin
            errors++;
            $display("FAIL reset_pre_wait: got ce=%b oe=%b expected ce=1101 oe=0", o_ce, o_oe);
        end
        #1 clr_n = 1'b0;
        #1;
        checks++;
        if ({o_ce, o_oe, o_rv, o_ready, o_addr} !== {4'hF, 1'b1, 1'b0, 1'b1, 19'h0}) begin
            errors++;
            $display("FAIL async_reset: got ce=%b oe=%b rv=%b rdy=%b addr=%h expected 1111 1 0 1 00000",
                     o_ce, o_oe, o_rv, o_ready, o_addr);
        end
        @(negedge clk);
        clr_n  = 1'b1;
        saw_rv = 1'b0;
        repeat (wc + 4) begin
            @(negedge clk);
            if (o_rv) saw_rv = 1'b1;
        end
        checks++;
        if ({saw_rv, o_ready, o_ce} !== {1'b0, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL reset_no_result: got rv_seen=%b rdy=%b ce=%b expected 0 1 1111",
                     saw_rv, o_ready, o_ce);
        end
    endtask

    task automatic test_basic();
        sel = 0; wc = 2;
        start({6'd2, 19'h1ABCD}, 16'hBEEF);
        watch(2, 19'h1ABCD, 16'hBEEF, 0, 1'b0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if ({o_rv, o_data} !== {1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL pulse_hold: got rv=%b data=%h expected rv=0 data=beef", o_rv, o_data);
        end
        random_reads(6);
    endtask

    task automatic test_wait0();
        sel = 1; wc = 0;
        @(negedge clk);
        start({6'd2, 19'h1ABCD}, 16'hBEEF);
        watch(2, 19'h1ABCD, 16'hBEEF, 0, 1'b0, 1'b0, '0);
        random_reads(6);
    endtask

    task automatic test_out_of_range();
        int            c;
        logic [AW-1:0] w;
        sel = 0; wc = 2;
        for (int k = 0; k < 4; k++) begin
            c = (k == 0) ? 5 : int'($urandom_range(NC, (1 << CW) - 1));
            w = (k == 0) ? 19'h00010 : AW'($urandom);
            @(negedge clk);
            start({CW'(c), w}, DW'($urandom));
            @(negedge clk);
            req_valid = 1'b0;
            checks++;
            if ({o_ce, o_oe, o_rv} !== {4'hF, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL oor_no_access: got ce=%b oe=%b rv=%b expected 1111 1 0", o_ce, o_oe, o_rv);
            end
            @(negedge clk);
            checks++;
            if ({o_rv, o_err, o_data, o_ce, o_oe, o_ready} !==
                {1'b1, 1'b1, 16'h0, 4'hF, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL oor_result chip %0d: got rv=%b err=%b data=%h ce=%b oe=%b rdy=%b expected 1 1 0000 1111 1 1",
                         c, o_rv, o_err, o_data, o_ce, o_oe, o_ready);
            end
            @(negedge clk);
            checks++;
            if (o_rv !== 1'b0) begin
                errors++;
                $display("FAIL oor_pulse: got rv=%b expected 0", o_rv);
            end
        end
        random_reads(2);
    endtask

    task automatic test_backpressure();
        logic [AW+CW-1:0] a, b;
        logic [DW-1:0]    da, db;
        sel = 0; wc = 2;
        a  = {6'd1, AW'($urandom)};
        b  = {6'd3, AW'($urandom)};
        da = DW'($urandom);
        db = DW'($urandom);
        @(negedge clk);
        start(a, da);
        watch(1, a[AW-1:0], da, 0, 1'b1, 1'b1, b);
        dq = db;
        watch(3, b[AW-1:0], db, B2B ? 1 : 0, 1'b0, 1'b0, '0);
    endtask

`ifdef SRAM_RD_BACK2BACK_EN
    task automatic test_back_to_back();
        logic [AW+CW-1:0] a, b;
        logic [DW-1:0]    da, db;
        for (int s = 0; s < 2; s++) begin
            sel = s; wc = (s == 1) ? 0 : 2;
            a  = {6'd0, AW'($urandom)};
            b  = {6'd3, AW'($urandom)};
            da = DW'($urandom);
            db = DW'($urandom);
            @(negedge clk);
            start(a, da);
            watch(0, a[AW-1:0], da, 0, 1'b0, 1'b1, b);
            dq = db;
            watch(3, b[AW-1:0], db, 1, 1'b0, 1'b0, '0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wait0();
        test_out_of_range();
        test_backpressure();
`ifdef SRAM_RD_BACK2BACK_EN
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1);
    end

endmodule
